// File: rtl/fir_mac_engine.sv
// Single-MAC FIR engine: 256-entry circular sample history, one tap per cycle,
// rounded and saturated Q1.15 result per accepted sample.
module fir_mac_engine #(
   parameter int ACC_WIDTH = 40,
   parameter int COEF_FRAC = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_valid,
   input  logic [15:0] sample_in,
   input  logic [7:0]  taps_per_filter,
   input  logic        hist_clr,
   output logic [7:0]  coef_rd_addr,
   input  logic [15:0] coefficients,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [2:0] {CLEAR, IDLE, MAC, FLUSH, DONE} state_t;

   localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) <<< (COEF_FRAC - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = ACC_WIDTH'(-32768);

   state_t                       r_state;
   state_t                       w_next_state;
   logic [15:0]                  r_hist [256];
   logic [7:0]                   r_wr_ptr;
   logic [7:0]                   r_base;
   logic [7:0]                   r_last;
   logic [7:0]                   r_k;
   logic signed [31:0]           r_prod;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic [15:0]                  r_data_out;
   logic                         r_data_valid;
   logic                         r_overrun;

   logic                         w_accept;
   logic                         w_busy;
   logic                         w_hist_we;
   logic [15:0]                  w_hist_wdata;
   logic [7:0]                   w_rd_idx;
   logic signed [15:0]           w_samp;
   logic signed [15:0]           w_coef;
   logic signed [31:0]           w_prod;
   logic signed [ACC_WIDTH-1:0]  w_shifted;
   logic [15:0]                  w_sat;

   assign w_busy       = (r_state != IDLE);
   assign w_accept     = (r_state == IDLE) && sample_valid;
   assign w_hist_we    = reset_n && ((r_state == CLEAR) || w_accept);
   assign w_hist_wdata = (r_state == CLEAR) ? 16'h0000 : sample_in;

   // Taps walk backwards in time from the newest sample, wrapping mod 256.
   assign w_rd_idx  = r_base - r_k;
   assign w_samp    = r_hist[w_rd_idx];
   assign w_coef    = coefficients;
   assign w_prod    = 32'(w_coef) * 32'(w_samp);
   assign w_shifted = (r_acc + ROUND_BIAS) >>> COEF_FRAC;

   always_comb begin
      w_sat = w_shifted[15:0];
      if (w_shifted > SAT_MAX) begin
         w_sat = 16'h7FFF;
      end else if (w_shifted < SAT_MIN) begin
         w_sat = 16'h8000;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         CLEAR:   if (r_wr_ptr == 8'hFF) w_next_state = IDLE;
         IDLE:    if (sample_valid) w_next_state = MAC;
                  else if (hist_clr) w_next_state = CLEAR;
         MAC:     if (r_k == r_last) w_next_state = FLUSH;
         FLUSH:   w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_hist_we) begin
         r_hist[r_wr_ptr] <= w_hist_wdata;
      end
   end

   // The product lags the tap index by one cycle, so MAC skips the add at k==0
   // and FLUSH folds in the last product.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= CLEAR;
         r_wr_ptr     <= 8'd0;
         r_base       <= 8'd0;
         r_last       <= 8'd0;
         r_k          <= 8'd0;
         r_prod       <= 32'sd0;
         r_acc        <= '0;
         r_data_out   <= 16'h0000;
         r_data_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_data_valid <= 1'b0;
         r_overrun    <= sample_valid && w_busy;
         case (r_state)
            CLEAR: r_wr_ptr <= r_wr_ptr + 8'd1;
            IDLE: begin
               if (sample_valid) begin
                  r_base   <= r_wr_ptr;
                  r_last   <= taps_per_filter;
                  r_wr_ptr <= r_wr_ptr + 8'd1;
                  r_acc    <= '0;
                  r_k      <= 8'd0;
               end else if (hist_clr) begin
                  r_wr_ptr <= 8'd0;
               end
            end
            MAC: begin
               r_prod <= w_prod;
               r_k    <= r_k + 8'd1;
               if (r_k != 8'd0) begin
                  r_acc <= r_acc + ACC_WIDTH'(r_prod);
               end
            end
            FLUSH: r_acc <= r_acc + ACC_WIDTH'(r_prod);
            DONE: begin
               r_data_out   <= w_sat;
               r_data_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign coef_rd_addr = (r_state == MAC) ? r_k : 8'd0;
   assign data_out     = r_data_out;
   assign data_valid   = r_data_valid;
   assign busy         = w_busy;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: a tap-sum reference model feeds a
// scoreboard of expected outputs and the exact period each must appear in.
module tb_fir_mac_engine;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_valid;
   logic [15:0] sample_in;
   logic [7:0]  taps_per_filter;
   logic        hist_clr;
   logic [7:0]  coef_rd_addr;
   logic [15:0] coefficients;
   logic [15:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        overrun;

   logic [15:0]        coefMem [256];
   logic signed [15:0] mHist [256];
   logic [7:0]         mWr;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;
   exp_t sbQ[$];

   int checks   = 0;
   int failures = 0;
   int negCount = 0;

   always #5 clk = ~clk;

   assign coefficients = coefMem[coef_rd_addr];

   fir_mac_engine #(.ACC_WIDTH(40), .COEF_FRAC(15)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sample_valid    (sample_valid),
      .sample_in       (sample_in),
      .taps_per_filter (taps_per_filter),
      .hist_clr        (hist_clr),
      .coef_rd_addr    (coef_rd_addr),
      .coefficients    (coefficients),
      .data_out        (data_out),
      .data_valid      (data_valid),
      .busy            (busy),
      .overrun         (overrun)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < 256; i++) mHist[i] = 16'sd0;
      mWr = 8'd0;
   endtask

   task automatic modelAccept(input logic [15:0] x, input logic [7:0] taps, output logic [15:0] y);
      logic [7:0] base;
      logic [7:0] idx;
      longint     sum;
      longint     r;
      mHist[mWr] = x;
      base = mWr;
      mWr  = mWr + 8'd1;
      sum  = 0;
      for (int k = 0; k <= int'(taps); k++) begin
         idx = base - 8'(k);
         sum += longint'($signed(coefMem[k])) * longint'(mHist[idx]);
      end
      r = (sum + 64'sd16384) >>> 15;
      if (r > 32767) y = 16'h7FFF;
      else if (r < -32768) y = 16'h8000;
      else y = 16'(r);
   endtask

   // Every period: data_valid must be high exactly when the head of the
   // scoreboard is due, and then data_out must match it.
   always @(negedge clk) begin : monitor
      exp_t e;
      logic expValid;
      negCount++;
      expValid = (sbQ.size() != 0) && (sbQ[0].cyc == negCount);
      checkVal("data_valid", {31'd0, data_valid}, {31'd0, expValid});
      if (expValid) begin
         e = sbQ.pop_front();
         checkVal("data_out", {16'd0, data_out}, {16'd0, e.data});
      end
   end

   // Caller sits at negedge+1 of the period to drive; returns one period later.
   task automatic applyStimulus(input logic [15:0] x, input logic expectAccept);
      logic [15:0] y;
      checkVal("busy_at_send", {31'd0, busy}, {31'd0, ~expectAccept});
      sample_in    = x;
      sample_valid = 1'b1;
      if (expectAccept) begin
         modelAccept(x, taps_per_filter, y);
         sbQ.push_back('{data: y, cyc: negCount + int'(taps_per_filter) + 4});
      end
      @(negedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic checkOutput(input int limit);
      int n = 0;
      while (sbQ.size() != 0 && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      checkVal("drain_timeout", sbQ.size(), 0);
      sbQ.delete();
   endtask

   task automatic countBusy(input int periods, input string tag);
      int busyCnt = 0;
      for (int i = 0; i < periods; i++) begin
         if (busy === 1'b1) busyCnt++;
         checkVal({tag, "_dout"}, {16'd0, data_out}, 32'd0);
         @(negedge clk); #1;
      end
      checkVal({tag, "_busy_cycles"}, busyCnt, 256);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busyCnt;
      reset_n         = 1'b0;
      sample_valid    = 1'b0;
      sample_in       = 16'h0000;
      hist_clr        = 1'b0;
      taps_per_filter = 8'd3;
      for (int i = 0; i < 256; i++) coefMem[i] = 16'h0000;
      modelClear();

      // Reset values, then 256 busy CLEAR periods out of 300.
      repeat (3) @(negedge clk);
      #1;
      checkVal("rst_data_out", {16'd0, data_out}, 32'd0);
      checkVal("rst_overrun", {31'd0, overrun}, 32'd0);
      checkVal("rst_coef_addr", {24'd0, coef_rd_addr}, 32'd0);
      checkVal("rst_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b1;
      countBusy(300, "por");
      $display("[TB] reset sequence done");

      // Impulse response.
      coefMem[0] = 16'h4000; coefMem[1] = 16'h2000;
      coefMem[2] = 16'h1000; coefMem[3] = 16'h0800;
      applyStimulus(16'h7FFF, 1'b1);
      checkVal("mac_addr_k0", {24'd0, coef_rd_addr}, 32'd0);
      @(negedge clk); #1;
      checkVal("mac_addr_k1", {24'd0, coef_rd_addr}, 32'd1);
      checkOutput(20);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h0000, 1'b1);
         checkOutput(20);
      end
      checkVal("idle_coef_addr", {24'd0, coef_rd_addr}, 32'd0);
      $display("[TB] impulse done");

      // History clear; a second hist_clr while clearing must not extend it.
      hist_clr = 1'b1;
      @(negedge clk); #1;
      hist_clr = 1'b0;
      modelClear();
      busyCnt = 0;
      for (int i = 0; i < 260; i++) begin
         if (busy === 1'b1) busyCnt++;
         if (i == 100) hist_clr = 1'b1;
         if (i == 101) hist_clr = 1'b0;
         @(negedge clk); #1;
      end
      checkVal("histclr_busy_cycles", busyCnt, 256);
      applyStimulus(16'h1000, 1'b1);
      checkOutput(20);
      $display("[TB] hist_clr done");

      // Overrun two periods after an accept; taps change mid-MAC is ignored.
      applyStimulus(16'h0100, 1'b1);
      taps_per_filter = 8'd255;
      @(negedge clk); #1;
      applyStimulus(16'h7777, 1'b0);
      checkVal("overrun_pulse", {31'd0, overrun}, 32'd1);
      @(negedge clk); #1;
      checkVal("overrun_single", {31'd0, overrun}, 32'd0);
      taps_per_filter = 8'd3;
      checkOutput(20);
      applyStimulus(16'h0000, 1'b1);
      checkOutput(20);
      $display("[TB] overrun done");

      // Saturation both ways.
      for (int i = 0; i < 4; i++) coefMem[i] = 16'h7FFF;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h7FFF, 1'b1);
         checkOutput(20);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h8000, 1'b1);
         checkOutput(20);
      end
      $display("[TB] saturation done");

      // Full 256-tap filter with the history pointer wrapping.
      taps_per_filter = 8'd255;
      for (int i = 0; i < 256; i++) coefMem[i] = 16'h0080;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(16'h0100, 1'b1);
         checkOutput(300);
      end
      $display("[TB] wrap done");

      // Reset in the middle of MAC: no output, then a fresh CLEAR.
      applyStimulus(16'h0100, 1'b1);
      @(negedge clk); #1;
      reset_n = 1'b0;
      sbQ.delete();
      @(negedge clk); #1;
      reset_n = 1'b1;
      modelClear();
      countBusy(300, "abort");
      taps_per_filter = 8'd3;
      applyStimulus(16'h2000, 1'b1);
      checkOutput(20);
      $display("[TB] reset abort done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
